// File: rtl/uart_arb_pkg.sv
// Shared types and default configuration for the UART TX frame arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default parameter values, index-wrap helper.
package uart_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_NUM_REQ        = 3;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Index reached by stepping 'step' positions past 'base' in a ring of 'n'.
  function automatic int ring_step(input int base, input int step, input int n);
    int r;
    r = base + step;
    while (r >= n) r = r - n;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and TX-FIFO-side handshake bundle for the UART TX arbiter.
// Latency: n/a (wires only).
// Backpressure: req_ready / out_ready carry the valid-ready stall.
//
// Signals:
//   req_valid/req_data/req_last/req_ready : per-requester byte stream
//   out_data/out_valid/out_ready          : merged byte stream to the TX FIFO
// Modports: master = requester/FIFO environment, slave = arbiter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_data, out_valid
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_data, out_valid
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first requesting index strictly after last_grant.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
//
// Ports:
//   req        : request vector
//   last_grant : index of the most recent owner
//   pick       : one-hot winner, zero when no request
//   any        : at least one request present
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         pick,
  output logic                       any
);

  logic found;

  // Two passes: indices above last_grant first, then wrap around to the
  // bottom (which includes last_grant itself as the lowest priority).
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i > int'(last_grant))) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter merging requester byte streams into one UART TX FIFO.
// Latency: one arbitration cycle in IDLE, then bytes pass combinationally from owner to FIFO.
// Backpressure: out_ready goes straight back to the owner's req_ready; non-owners see 0.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   ena            : global enable, low freezes all state and blocks transfers
//   bus (slave)    : req_valid/req_data/req_last/req_ready, out_data/out_valid/out_ready
//   grant          : one-hot current frame owner, zero when idle
//   timeout_pulse  : one-cycle abort indication
// Build option: define UART_ARB_TIMEOUT_EN to add the idle-owner abort counter
// (TIMEOUT_CYCLES); otherwise the owner keeps the grant until its last byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  uart_tx_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               timeout_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // Starting "last owner" at the top index makes requester 0 win first.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;

  logic [NUM_REQ-1:0]     pick;
  logic                   any_req;
  logic [DATA_WIDTH-1:0]  own_dat;
  logic                   own_vld;
  logic                   own_last;
  logic                   xfer_phase;
  logic                   xfer_fire;
  logic                   to_hit;
  logic [NUM_REQ-1:0]     rdy;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .pick       (pick),
    .any        (any_req)
  );

  // Owner's byte lane, selected with constant part-selects.
  always_comb begin
    own_dat  = '0;
    own_vld  = 1'b0;
    own_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_dat  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        own_vld  = bus.req_valid[i];
        own_last = bus.req_last[i];
      end
    end
  end

  assign xfer_phase = ena && (state_q == XFER);
  assign xfer_fire  = xfer_phase && own_vld && bus.out_ready;

  always_comb begin
    rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rdy[i] = xfer_phase && grant_q[i] && bus.out_ready;
    end
  end

  assign bus.req_ready = rdy;
  assign bus.out_valid = xfer_phase && own_vld;
  assign bus.out_data  = (state_q == XFER) ? own_dat : '0;
  assign grant         = grant_q;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q;

  // Only cycles where the owner has nothing to offer count; a FIFO stall
  // with data pending is the consumer's fault, not the owner's.
  always_comb begin
    cnt_d  = cnt_q;
    to_hit = 1'b0;
    if (xfer_phase) begin
      if (own_vld) begin
        if (bus.out_ready) cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        to_hit = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (ena && (state_q == IDLE)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= to_hit;
    end
  end

  assign timeout_pulse = pulse_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign to_hit             = 1'b0;
  assign timeout_pulse      = 1'b0;
`endif

  // Next-state / grant logic. Everything holds while ena is low.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_d = XFER;
            grant_d = pick;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (pick[i]) owner_d = IDX_W'(i);
            end
          end
        end
        XFER: begin
          if ((xfer_fire && own_last) || to_hit) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = owner_q;
          end
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner
// sequences and a randomized run against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int DW = 8;
  localparam int NR = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [NR-1:0] grant;
  logic          timeout_pulse;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .DATA_WIDTH     (DW),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .bus           (bus),
    .grant         (grant),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h required %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [2:0] v, input logic [2:0] l,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic ordy);
    ena           = e;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = {d2, d1, d0};
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- reference model (frame-level) ----------------
  int owner;   // -1 = nobody owns the TX path
  int lastg;
  int tcnt;
  bit mpulse;

  task automatic model_reset();
    owner  = -1;
    lastg  = NR - 1;
    tcnt   = 0;
    mpulse = 1'b0;
  endtask

  task automatic model_check();
    logic [2:0] eg, er;
    logic       ev;
    eg = (owner < 0) ? 3'b000 : 3'(1 << owner);
    ev = (owner >= 0) && ena && bus.req_valid[owner];
    er = (owner >= 0 && ena && bus.out_ready) ? 3'(1 << owner) : 3'b000;
    chk("rnd_grant", 32'(grant), 32'(eg));
    chk("rnd_out_valid", 32'(bus.out_valid), 32'(ev));
    chk("rnd_req_ready", 32'(bus.req_ready), 32'(er));
    chk("rnd_timeout", 32'(timeout_pulse), 32'(mpulse));
    if (ev) chk("rnd_out_data", 32'(bus.out_data), 32'(bus.req_data[owner*DW +: DW]));
  endtask

  task automatic model_step();
    int nxt;
    mpulse = 1'b0;
    if (!ena) return;
    if (owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        nxt = (lastg + k) % NR;
        if (bus.req_valid[nxt]) begin
          owner = nxt;
          tcnt  = 0;
          break;
        end
      end
    end else if (bus.req_valid[owner]) begin
      if (bus.out_ready) begin
        tcnt = 0;
        if (bus.req_last[owner]) begin
          lastg = owner;
          owner = -1;
        end
      end
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      tcnt++;
      if (tcnt == TO) begin
        mpulse = 1'b1;
        lastg  = owner;
        owner  = -1;
        tcnt   = 0;
      end
`endif
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       e;
    logic [2:0] v;
    logic [2:0] l;
    logic [7:0] d0;
    logic [7:0] d2;
    logic [2:0] g;
    logic [2:0] rdy;
    logic       ov;
    logic [7:0] od;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int held;
    int seen;
    logic [2:0] eg;

    // Two-requester start, 3-byte frame from req0, then round-robin to req2.
    tbl[0] = '{1'b1, 3'b101, 3'b000, 8'h41, 8'h99, 3'b000, 3'b000, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 3'b101, 3'b000, 8'h41, 8'h99, 3'b001, 3'b001, 1'b1, 8'h41};
    tbl[2] = '{1'b1, 3'b101, 3'b000, 8'h42, 8'h99, 3'b001, 3'b001, 1'b1, 8'h42};
    tbl[3] = '{1'b1, 3'b101, 3'b001, 8'h43, 8'h99, 3'b001, 3'b001, 1'b1, 8'h43};
    tbl[4] = '{1'b1, 3'b101, 3'b100, 8'h50, 8'h99, 3'b000, 3'b000, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 3'b101, 3'b100, 8'h50, 8'h99, 3'b100, 3'b100, 1'b1, 8'h99};
    tbl[6] = '{1'b1, 3'b001, 3'b001, 8'h44, 8'h00, 3'b000, 3'b000, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 3'b001, 3'b001, 8'h44, 8'h00, 3'b001, 3'b001, 1'b1, 8'h44};
    tbl[8] = '{1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3'b000, 1'b0, 8'h00};

    do_reset();
    @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_timeout", 32'(timeout_pulse), 32'd0);
    tick();

    for (int r = 0; r < 9; r++) begin
      drive(tbl[r].e, tbl[r].v, tbl[r].l, tbl[r].d0, 8'h00, tbl[r].d2, 1'b1);
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", r), 32'(grant), 32'(tbl[r].g));
      chk($sformatf("tbl%0d_req_ready", r), 32'(bus.req_ready), 32'(tbl[r].rdy));
      chk($sformatf("tbl%0d_out_valid", r), 32'(bus.out_valid), 32'(tbl[r].ov));
      if (tbl[r].ov) chk($sformatf("tbl%0d_out_data", r), 32'(bus.out_data), 32'(tbl[r].od));
      tick();
    end

    // All three sending 1-byte frames continuously: 0,1,2,0,1,2 with gaps.
    do_reset();
    drive(1'b1, 3'b111, 3'b111, 8'hA0, 8'hA1, 8'hA2, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      eg = (k % 2 == 1) ? 3'(1 << ((k / 2) % 3)) : 3'b000;
      chk($sformatf("rr_cyc%0d_grant", k), 32'(grant), 32'(eg));
      if (k % 2 == 1)
        chk($sformatf("rr_cyc%0d_data", k), 32'(bus.out_data), 32'(8'hA0 + (k / 2) % 3));
      tick();
    end

    // FIFO stall for 5 cycles in the middle of a req1 frame.
    do_reset();
    drive(1'b1, 3'b010, 3'b000, 8'h00, 8'h10, 8'h00, 1'b1);
    tick();
    @(negedge clk);
    chk("stall_first_data", 32'(bus.out_data), 32'h10);
    tick();
    drive(1'b1, 3'b011, 3'b000, 8'hE0, 8'h11, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hold_data", 32'(bus.out_data), 32'h11);
      chk("stall_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_no_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_grant", 32'(grant), 32'b010);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_resume_ready", 32'(bus.req_ready), 32'b010);
    chk("stall_resume_data", 32'(bus.out_data), 32'h11);
    tick();
    drive(1'b1, 3'b011, 3'b010, 8'hE0, 8'h12, 8'h00, 1'b1);
    @(negedge clk);
    chk("stall_last_data", 32'(bus.out_data), 32'h12);
    chk("stall_last_grant", 32'(grant), 32'b010);
    tick();
    @(negedge clk);
    chk("stall_gap_grant", 32'(grant), 32'd0);
    tick();
    @(negedge clk);
    chk("stall_next_grant", 32'(grant), 32'b001);
    tick();

    // Owner goes quiet after its first byte.
    do_reset();
    drive(1'b1, 3'b001, 3'b000, 8'h55, 8'h00, 8'h00, 1'b1);
    tick();
    @(negedge clk);
    chk("to_byte1_data", 32'(bus.out_data), 32'h55);
    chk("to_byte1_ready", 32'(bus.req_ready), 32'b001);
    tick();
    drive(1'b1, 3'b010, 3'b010, 8'h55, 8'h66, 8'h00, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    seen = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (seen == 0 && timeout_pulse) seen = n;
      if (seen != 0) break;
      tick();
    end
    chk("to_pulse_cycle", 32'(seen), 32'd17);
    tick();
    @(negedge clk);
    chk("to_pulse_width", 32'(timeout_pulse), 32'd0);
    chk("to_next_grant", 32'(grant), 32'b010);
    tick();
`else
    held = 0;
    seen = 0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (grant === 3'b001) held++;
      if (timeout_pulse !== 1'b0) seen++;
      tick();
    end
    chk("no_to_grant_held", 32'(held), 32'd120);
    chk("no_to_pulse", 32'(seen), 32'd0);
`endif

    // Asynchronous reset in the middle of a req2 frame.
    do_reset();
    drive(1'b1, 3'b100, 3'b000, 8'h00, 8'h00, 8'h77, 1'b1);
    tick();
    @(negedge clk);
    chk("rst_mid_grant", 32'(grant), 32'b100);
    chk("rst_mid_data", 32'(bus.out_data), 32'h77);
    tick();
    bus.req_data = {8'h78, 8'h00, 8'h00};
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_grant", 32'(grant), 32'd0);
    chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_async_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 3'b101, 3'b000, 8'h31, 8'h00, 8'h78, 1'b1);
    @(negedge clk);
    chk("rst_after_idle", 32'(grant), 32'd0);
    tick();
    @(negedge clk);
    chk("rst_after_grant", 32'(grant), 32'b001);
    chk("rst_after_data", 32'(bus.out_data), 32'h31);
    tick();

    // Enable dropped for 4 cycles while a last byte is pending.
    do_reset();
    drive(1'b1, 3'b001, 3'b000, 8'h21, 8'h00, 8'h00, 1'b1);
    tick();
    @(negedge clk);
    chk("ena_first_data", 32'(bus.out_data), 32'h21);
    tick();
    drive(1'b0, 3'b001, 3'b001, 8'h22, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ena_off_valid", 32'(bus.out_valid), 32'd0);
      chk("ena_off_ready", 32'(bus.req_ready), 32'd0);
      chk("ena_off_grant", 32'(grant), 32'b001);
      tick();
    end
    ena = 1'b1;
    @(negedge clk);
    chk("ena_on_valid", 32'(bus.out_valid), 32'd1);
    chk("ena_on_data", 32'(bus.out_data), 32'h22);
    chk("ena_on_ready", 32'(bus.req_ready), 32'b001);
    tick();
    drive(1'b1, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    chk("ena_done_grant", 32'(grant), 32'd0);
    tick();

    // Randomized traffic against the frame-level model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 7) != 0),
            3'($urandom_range(0, 7) | $urandom_range(0, 7)),
            3'($urandom_range(0, 7) & $urandom_range(0, 7)),
            8'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 4) != 0));
      @(negedge clk);
      model_check();
      model_step();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of every data path.
REQ-002 SHALL have parameter NUM_REQ, default 3, number of frame requesters (2..8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, idle-abort limit (used only under UART_ARB_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_last  input  NUM_REQ  marks final byte of a frame.
REQ-010 SHALL have port req_ready  output  NUM_REQ  byte accepted from requester i when req_valid[i]&&req_ready[i].
REQ-011 SHALL have port out_data  output  DATA_WIDTH  byte to TX FIFO (tx_data_in).
REQ-012 SHALL have port out_valid  output  1  byte present (tx_data_in_valid).
REQ-013 SHALL have port out_ready  input  1  TX FIFO can accept (not full).
REQ-014 SHALL have port grant  output  NUM_REQ  one-hot current owner, zero when idle.
REQ-015 SHALL have port timeout_pulse  output  1  one-cycle abort indication.

Function
REQ-016 SHALL implement FSM with states IDLE and XFER.
REQ-017 In IDLE with ena=1 and any req_valid set, SHALL register grant to the first requesting index after last_grant (round-robin, wrapping NUM_REQ-1 to 0) and enter XFER next cycle.
REQ-018 Arbitration latency SHALL be exactly one cycle: first byte may transfer in the cycle after the arbitration cycle.
REQ-019 In XFER, out_data=req_data[g], out_valid=req_valid[g], req_ready[g]=out_ready, combinationally; req_ready of all non-owners SHALL be 0.
REQ-020 In IDLE, out_valid and all req_ready SHALL be 0.
REQ-021 Grant SHALL be held for the whole frame; other requesters never preempt.
REQ-022 Transfer of a byte with req_last[g]=1 SHALL return FSM to IDLE, set last_grant=g, clear grant next cycle.
REQ-023 Back-to-back frames SHALL incur exactly one idle cycle (the IDLE arbitration cycle).
REQ-024 out_ready low SHALL stall without data loss; out_data/out_valid stable while owner holds valid.
REQ-025 ena=0 SHALL force out_valid=0 and all req_ready=0 and hold FSM, grant, last_grant, counter.
REQ-026 Single-byte frame (req_last on first byte) SHALL be legal and complete in one XFER cycle.

Reset
REQ-027 rst_n low SHALL asynchronously set state=IDLE, grant=0, last_grant=NUM_REQ-1 (requester 0 wins first), timeout counter=0, timeout_pulse=0, out_valid=0, req_ready=0.
REQ-028 Reset mid-frame SHALL abandon the frame; no partial continuation after release.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN defined: counter increments each XFER cycle with ena=1 and req_valid[g]=0, clears on every transfer and on entering XFER; reaching TIMEOUT_CYCLES SHALL return to IDLE, set last_grant=g, pulse timeout_pulse for one cycle.
REQ-030 Stall cycles with req_valid[g]=1 and out_ready=0 SHALL NOT count toward timeout.
REQ-031 Macro undefined: no counter logic, timeout_pulse tied 0, owner held indefinitely.

Structure
REQ-032 Shared package uart_arb_pkg SHALL hold the state enum (IDLE, XFER) and default parameter constants.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs request vector, last_grant; output one-hot pick, any flag).

Verification
REQ-034 Reset release, req 0 and 2 valid simultaneously, out_ready=1 -> grant=001, req0 3-byte frame 0x41,0x42,0x43 on out_data in consecutive cycles, one idle cycle, then grant=100.
REQ-035 All three requesters continuously sending 1-byte frames -> grant order 0,1,2,0,1,2 with one idle cycle between each.
REQ-036 out_ready=0 for 5 cycles mid-frame of req1 -> out_data holds byte, no req_ready, frame resumes intact, req0 valid meanwhile never granted.
REQ-037 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, owner drops valid after byte 1 -> timeout_pulse high exactly 16 cycles later, next requester granted; without macro, grant held for 100+ cycles.
REQ-038 rst_n asserted mid-frame of req2 -> outputs zero immediately; after release req0 wins first arbitration.
REQ-039 ena=0 for 4 cycles during XFER -> no transfers, state and grant unchanged, resumes on ena=1.
